// File: rtl/dac_spi_master_pkg.sv
// Shared control-loop definitions for the DAC command path.
// Latency: n/a (types, constants and a frame-packing helper only).
// Backpressure: n/a.
package dac_spi_master_pkg;

  // DAC frame geometry: 4-bit register code followed by 20-bit data
  localparam int DAC_WID      = 24;
  localparam int DAC_DATA_WID = 20;
  localparam int DAC_CMD_WID  = DAC_WID - DAC_DATA_WID;

  // DAC register codes issued by the control loop
  localparam logic [DAC_CMD_WID-1:0] DAC_CMD_WRITE = 4'b0001;
  localparam logic [DAC_CMD_WID-1:0] DAC_CMD_READ  = 4'b1001;

  // One command word as it goes on the wire, MSB first
  typedef struct packed {
    logic [DAC_CMD_WID-1:0]  cmd;
    logic [DAC_DATA_WID-1:0] data;
  } dac_frame_t;

  // Builds a wire-order command word from a register code and data field
  function automatic logic [DAC_WID-1:0] dac_pack(
    input logic [DAC_CMD_WID-1:0]  cmd,
    input logic [DAC_DATA_WID-1:0] data
  );
    dac_frame_t f;
    f.cmd  = cmd;
    f.data = data;
    return f;
  endfunction

endpackage

// File: rtl/dac_spi_master_half_timer.sv
// Loadable down-counter pacing the SETUP wait and every SCK half-period.
// Latency: tick asserts load_val cycles after a load, then holds at zero.
// Backpressure: none; a new load always overrides the running count.
module spi_half_timer #(
  parameter int TIMER_WID = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [TIMER_WID-1:0] i_load_val,
  output logic                 o_tick
);

  logic [TIMER_WID-1:0] r_cnt;

  // Reload on request, otherwise count down and park at zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TIMER_WID'(1);
    end
  end

  // The wait is over whenever the count has drained
  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/dac_spi_master.sv
// Mode-1 SPI master moving one full DAC frame out/in per arm/finished handshake.
// Latency: finished rises SS_WAIT + 2*WID*HALF_PERIOD cycles after arm is sampled.
// Backpressure: arm is level-held by the caller; dropping it mid-frame aborts, dropping it in DONE releases.
module dac_spi_master
  import dac_spi_master_pkg::*;
#(
  parameter int WID         = DAC_WID,
  parameter int WID_LEN     = 5,
  parameter int HALF_PERIOD = 1,
  parameter int TIMER_WID   = 4,
  parameter int SS_WAIT     = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WID-1:0] to_dac,
  output logic [WID-1:0] from_dac,
  input  logic           ss,
  input  logic           arm,
  output logic           finished,
  output logic           sck,
  output logic           mosi,
  input  logic           miso,
  output logic           cs_n
);

  // Timer reload values: the counter ticks once it has drained to zero,
  // so a reload of N-1 spaces consecutive events exactly N cycles apart.
  localparam logic [TIMER_WID-1:0] SETUP_LOAD = TIMER_WID'(SS_WAIT - 1);
  localparam logic [TIMER_WID-1:0] HALF_LOAD  = TIMER_WID'(HALF_PERIOD - 1);
  localparam logic [WID_LEN-1:0]   LAST_BIT   = WID_LEN'(WID - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCK_HIGH,
    ST_SCK_LOW,
    ST_DONE
  } state_t;

  state_t               r_state;
  logic [WID-1:0]       r_tx;
  logic [WID-1:0]       r_rx;
  logic [WID_LEN-1:0]   r_bit_cnt;

  logic                 w_start;
  logic                 w_tick;
  logic                 w_tmr_load;
  logic [TIMER_WID-1:0] w_tmr_val;
  logic                 w_busy;

  spi_half_timer #(
    .TIMER_WID (TIMER_WID)
  ) u_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_tick     (w_tick)
  );

  // Decide when the shared timer restarts and with which interval
  always_comb begin
    w_start    = arm && ss && !finished;
    w_busy     = (r_state == ST_SETUP) || (r_state == ST_SCK_HIGH) || (r_state == ST_SCK_LOW);
    w_tmr_load = 1'b0;
    w_tmr_val  = HALF_LOAD;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = SETUP_LOAD;
        end
      end
      // Each expiry starts the next half-period; the last fall also starts
      // the trailing low half-period that DONE waits out before finishing.
      ST_SETUP, ST_SCK_HIGH, ST_SCK_LOW: begin
        w_tmr_load = w_tick;
      end
      default: begin
        w_tmr_load = 1'b0;
      end
    endcase
  end

  // Transfer sequencer; every output pin is driven straight from a flop here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_tx      <= '0;
      r_rx      <= '0;
      r_bit_cnt <= '0;
      from_dac  <= '0;
      finished  <= 1'b0;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      cs_n      <= 1'b1;
    end else begin
      // Chip select belongs to the caller; it is only retimed here, so a
      // mid-frame drop shows up on cs_n while the frame carries on.
      cs_n <= ~ss;

      if (w_busy && !arm) begin
        // Abort: park the bus low, leave from_dac and finished alone
        sck     <= 1'b0;
        mosi    <= 1'b0;
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              r_tx      <= to_dac;
              r_rx      <= '0;
              r_bit_cnt <= '0;
              r_state   <= ST_SETUP;
            end
          end

          ST_SETUP, ST_SCK_LOW: begin
            // Rising edge launches the next bit for the slave to sample on the fall
            if (w_tick) begin
              sck     <= 1'b1;
              mosi    <= r_tx[WID-1];
              r_tx    <= {r_tx[WID-2:0], 1'b0};
              r_state <= ST_SCK_HIGH;
            end
          end

          ST_SCK_HIGH: begin
            // Falling edge captures the slave's bit, MSB arrives first
            if (w_tick) begin
              sck       <= 1'b0;
              r_rx      <= {r_rx[WID-2:0], miso};
              r_bit_cnt <= r_bit_cnt + WID_LEN'(1);
              if (r_bit_cnt == LAST_BIT) begin
                mosi    <= 1'b0;
                r_state <= ST_DONE;
              end else begin
                r_state <= ST_SCK_LOW;
              end
            end
          end

          ST_DONE: begin
            // Publish after the final low half-period; a held arm never retriggers
            if (!arm) begin
              finished <= 1'b0;
              r_state  <= ST_IDLE;
            end else if (!finished && w_tick) begin
              finished <= 1'b1;
              from_dac <= r_rx;
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_spi_master.sv
`timescale 1ns/1ps
module tb_dac_spi_master;
  import dac_spi_master_pkg::*;

  localparam int WID  = 24;
  localparam int HP   = 1;
  localparam int SSW  = 2;
  localparam int HP3  = 3;
  localparam int SSW3 = 4;
  localparam int LAT  = SSW  + 2 * WID * HP;
  localparam int LAT3 = SSW3 + 2 * WID * HP3;

  logic clk = 1'b0;
  logic rst;

  // default-parameter instance
  logic [WID-1:0] to_dac, from_dac;
  logic ss, arm, finished, sck, mosi, cs_n;
  logic miso = 1'b0;

  // slowed-down instance
  logic [WID-1:0] to_dac3, from_dac3;
  logic ss3, arm3, finished3, sck3, mosi3, cs_n3;
  logic miso3 = 1'b0;

  always #5 clk = ~clk;

  dac_spi_master u_dut (
    .clk(clk), .rst(rst), .to_dac(to_dac), .from_dac(from_dac), .ss(ss), .arm(arm),
    .finished(finished), .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  dac_spi_master #(.HALF_PERIOD(HP3), .SS_WAIT(SSW3)) u_dut3 (
    .clk(clk), .rst(rst), .to_dac(to_dac3), .from_dac(from_dac3), .ss(ss3), .arm(arm3),
    .finished(finished3), .sck(sck3), .mosi(mosi3), .miso(miso3), .cs_n(cs_n3)
  );

  typedef struct {
    logic [WID-1:0] tx;
    logic [WID-1:0] rx;
    int             start;
    bit             ss_drop;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int frame_id = 0;
  int frame3_id = 0;
  logic rst_q = 1'b1;
  logic [WID-1:0] slave_word  = '0;
  logic [WID-1:0] slave3_word = '0;
  logic [WID-1:0] last_rx     = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Slave devices: present the next response bit on each SCK rise
  int s_id = -1, s_idx = 0;
  always @(posedge sck) begin
    if (s_id != frame_id) begin s_id = frame_id; s_idx = 0; end
    miso = (s_idx < WID) ? slave_word[WID-1-s_idx] : 1'b0;
    s_idx++;
  end

  int s3_id = -1, s3_idx = 0;
  always @(posedge sck3) begin
    if (s3_id != frame3_id) begin s3_id = frame3_id; s3_idx = 0; end
    miso3 = (s3_idx < WID) ? slave3_word[WID-1-s3_idx] : 1'b0;
    s3_idx++;
  end

  // Monitor: observes the wire, pops the scoreboard when finished rises
  int m_id = 0, m_pulses = 0, m_run = 0, m_bad_runs = 0, m_cs_hi = 0, m_hold_bad = 0;
  logic [WID-1:0] m_mosi = '0;
  logic [WID-1:0] m_exp_from = '0;
  logic m_prev_sck = 1'b0, m_prev_fin = 1'b0;
  exp_t m_e;

  always @(negedge clk) begin
    if (rst_q) begin
      m_exp_from = '0;
    end else begin
      if (frame_id != m_id) begin
        m_id = frame_id; m_pulses = 0; m_run = 0; m_bad_runs = 0; m_cs_hi = 0; m_mosi = '0;
      end
      if (sck && !m_prev_sck) begin
        if (m_pulses > 0 && m_run != HP) m_bad_runs++;
        m_mosi = {m_mosi[WID-2:0], mosi};
        m_pulses++;
        m_run = 1;
      end else if (!sck && m_prev_sck) begin
        if (m_run != HP) m_bad_runs++;
        m_run = 1;
      end else begin
        m_run++;
      end
      if (cs_n) m_cs_hi++;
      if (finished && !m_prev_fin) begin
        check("finish_expected", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) begin
          m_e = sb_q.pop_front();
          check("from_dac",    64'(from_dac),        64'(m_e.rx));
          check("mosi_stream", 64'(m_mosi),          64'(m_e.tx));
          check("sck_pulses",  64'(m_pulses),        64'(WID));
          check("latency",     64'(cyc - m_e.start), 64'(LAT));
          check("sck_duty",    64'(m_bad_runs),      64'(0));
          check("cs_n_vs_ss",  64'(m_cs_hi != 0),    64'(m_e.ss_drop));
          check("from_dac_hold", 64'(m_hold_bad),    64'(0));
          m_exp_from = m_e.rx;
        end
      end else if (from_dac !== m_exp_from) begin
        m_hold_bad++;
      end
    end
    m_prev_sck = sck;
    m_prev_fin = finished;
  end

  task automatic arm_frame(input logic [WID-1:0] tx, input logic [WID-1:0] rx, input bit drop_ss);
    exp_t e;
    @(posedge clk); #1;
    to_dac = tx;
    slave_word = rx;
    frame_id++;
    arm = 1'b1;
    e.tx = tx; e.rx = rx; e.start = cyc + 1; e.ss_drop = drop_ss;
    sb_q.push_back(e);
    last_rx = rx;
  endtask

  task automatic wait_finish(input int budget);
    int n;
    n = 0;
    while (!finished && n < budget) begin @(negedge clk); n++; end
    if (!finished) check("finish_timeout", 64'(finished), 64'(1));
  endtask

  task automatic release_arm();
    @(posedge clk); #1;
    arm = 1'b0;
    @(negedge clk);
    check("finished_until_arm_seen", 64'(finished), 64'(1));
    @(negedge clk);
    check("finished_clear", 64'(finished), 64'(0));
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_a, cnt_b, falls, rises, first_rise, hi_bad, lo_bad, run, p3, fin_rel, a3;
    logic prev;
    logic [WID-1:0] tx3;

    rst = 1'b1; arm = 1'b0; ss = 1'b0; to_dac = '0;
    arm3 = 1'b0; ss3 = 1'b0; to_dac3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sck",      64'(sck),       64'(0));
    check("rst_mosi",     64'(mosi),      64'(0));
    check("rst_cs_n",     64'(cs_n),      64'(1));
    check("rst_finished", 64'(finished),  64'(0));
    check("rst_from_dac", 64'(from_dac),  64'(0));
    check("rst_sck3",     64'(sck3),      64'(0));
    @(posedge clk); #1;
    rst = 1'b0; ss = 1'b1; ss3 = 1'b1;
    repeat (2) @(negedge clk);
    check("cs_n_follows_ss", 64'(cs_n), 64'(0));

    // write frame, then hold arm after finish
    arm_frame(dac_pack(DAC_CMD_WRITE, 20'hFFFFF), 24'($urandom), 1'b0);
    wait_finish(200);
    cnt_a = 0; cnt_b = 0;
    repeat (10) begin
      @(negedge clk);
      if (sck) cnt_a++;
      if (!finished) cnt_b++;
    end
    check("no_retrigger_sck", 64'(cnt_a), 64'(0));
    check("finished_held",    64'(cnt_b), 64'(0));
    release_arm();

    // read-back frame with a known slave response
    arm_frame(dac_pack(DAC_CMD_READ, 20'($urandom)), 24'h9ABCDE, 1'b0);
    wait_finish(200);
    release_arm();

    // random frames, one with ss dropped mid-frame
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      arm_frame(24'($urandom), 24'($urandom), i == 3);
      if (i == 3) begin
        repeat (10) @(posedge clk);
        #1 ss = 1'b0;
        repeat (4) @(posedge clk);
        #1 ss = 1'b1;
      end
      wait_finish(200);
      release_arm();
    end

    // abort after the 7th falling edge
    @(posedge clk); #1;
    to_dac = 24'hFFFFFF; slave_word = 24'($urandom); frame_id++;
    arm = 1'b1;
    falls = 0; prev = 1'b0;
    for (int k = 0; k < 200 && falls < 7; k++) begin
      @(negedge clk);
      if (!sck && prev) falls++;
      prev = sck;
    end
    check("abort_reached_7th_fall", 64'(falls), 64'(7));
    arm = 1'b0;
    @(negedge clk);
    check("abort_sck",  64'(sck),  64'(0));
    check("abort_mosi", 64'(mosi), 64'(0));
    cnt_a = 0;
    repeat (60) begin
      @(negedge clk);
      if (finished || sck) cnt_a++;
    end
    check("abort_quiet",    64'(cnt_a),    64'(0));
    check("abort_from_dac", 64'(from_dac), 64'(last_rx));

    // reset while SCK is high for bit 12
    @(posedge clk); #1;
    to_dac = 24'($urandom); slave_word = 24'($urandom); frame_id++;
    arm = 1'b1;
    rises = 0; prev = 1'b0;
    for (int k = 0; k < 200 && rises < 13; k++) begin
      @(negedge clk);
      if (sck && !prev) rises++;
      prev = sck;
    end
    check("reset_reached_bit12", 64'(rises), 64'(13));
    rst = 1'b1; arm = 1'b0;
    @(negedge clk);
    check("midrst_sck",      64'(sck),      64'(0));
    check("midrst_mosi",     64'(mosi),     64'(0));
    check("midrst_cs_n",     64'(cs_n),     64'(1));
    check("midrst_finished", 64'(finished), 64'(0));
    check("midrst_from_dac", 64'(from_dac), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    arm_frame(24'($urandom), 24'($urandom), 1'b0);
    wait_finish(200);
    release_arm();

    // slowed-down instance: HALF_PERIOD=3, SS_WAIT=4
    @(posedge clk); #1;
    to_dac3 = 24'($urandom); slave3_word = 24'($urandom); frame3_id++;
    arm3 = 1'b1;
    a3 = cyc + 1;
    first_rise = -1; hi_bad = 0; lo_bad = 0; run = 0; p3 = 0; fin_rel = -1; tx3 = '0; prev = 1'b0;
    for (int k = 0; k < 400 && fin_rel < 0; k++) begin
      @(negedge clk);
      if (sck3 && !prev) begin
        if (p3 == 0) first_rise = cyc - a3;
        else if (run != HP3) lo_bad++;
        tx3 = {tx3[WID-2:0], mosi3};
        p3++;
        run = 1;
      end else if (!sck3 && prev) begin
        if (run != HP3) hi_bad++;
        run = 1;
      end else begin
        run++;
      end
      if (finished3) fin_rel = cyc - a3;
      prev = sck3;
    end
    check("slow_first_rise", 64'(first_rise), 64'(SSW3));
    check("slow_high_len",   64'(hi_bad),     64'(0));
    check("slow_low_len",    64'(lo_bad),     64'(0));
    check("slow_pulses",     64'(p3),         64'(WID));
    check("slow_finish_at",  64'(fin_rel),    64'(LAT3));
    check("slow_mosi",       64'(tx3),        64'(to_dac3));
    check("slow_from_dac",   64'(from_dac3),  64'(slave3_word));
    check("slow_cs_n",       64'(cs_n3),      64'(0));
    @(posedge clk); #1;
    arm3 = 1'b0;

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
